// File: rtl/ann_pkg.sv
// ann_pkg: shared state encoding, word sizes and array dimensions for the classifier datapath
package ann_pkg;
  localparam int WORD_W     = 32;
  localparam int ADDR_W_DEF = 16;
  localparam int IMG_WORDS  = 64;
  localparam int W01_WORDS  = 512;
  localparam int B01_WORDS  = 8;
  localparam int W12_WORDS  = 16;
  localparam int B12_WORDS  = 2;
  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_LOAD    = 3'd1;
  localparam logic [2:0] S_DRAIN   = 3'd2;
  localparam logic [2:0] S_WAIT    = 3'd3;
  localparam logic [2:0] S_CAPTURE = 3'd4;
  function automatic int beats(input int n);
    return (n + 1) / 2;
  endfunction
endpackage

// File: rtl/ann_strobe_delay.sv
// ann_strobe_delay: fixed-depth shift register aligning read strobes with ROM data
module ann_strobe_delay #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 18
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);
  logic [DEPTH-1:0][WIDTH-1:0] sr_q, sr_d;
  always_comb begin
    sr_d[0] = din;
    for (int i = 1; i < DEPTH; i++) sr_d[i] = sr_q[i-1];
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) sr_q <= '0;
    else sr_q <= sr_d;
  assign dout = sr_q[DEPTH-1];
endmodule

// File: rtl/ann_infer_sequencer.sv
// ann_infer_sequencer: start/busy/done controller for one classifier inference pass
module ann_infer_sequencer
  import ann_pkg::*;
#(
  parameter int NUM_WORDS    = 512,
  parameter int ADDR_W       = ADDR_W_DEF,
  parameter int ROM_LATENCY  = 2,
  parameter int PIPE_LATENCY = 24
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              class_in,
  output logic              busy,
  output logic [ADDR_W-1:0] rom_addr_a,
  output logic [ADDR_W-1:0] rom_addr_b,
  output logic              rom_rd,
  output logic              buf_wr_a,
  output logic              buf_wr_b,
  output logic [ADDR_W-1:0] buf_idx,
  output logic              done,
  output logic              class_out
);
  localparam logic [ADDR_W-1:0] LAST_K = ADDR_W'(beats(NUM_WORDS) - 1);
  localparam bit ODD = (NUM_WORDS % 2) == 1;
  logic [2:0] state_q, state_d;
  logic [ADDR_W-1:0] k_q, k_d;
  logic [7:0] cnt_q, cnt_d;
  logic class_q, class_d;
  logic last_beat, drain_end, wait_end, odd_valid;
  assign last_beat = k_q == LAST_K;
  assign drain_end = cnt_q == 8'(ROM_LATENCY - 1);
  assign wait_end  = cnt_q == 8'(PIPE_LATENCY - 1);
  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    cnt_d   = cnt_q;
    class_d = class_q;
    case (state_q)
      S_IDLE: if (start) begin
        state_d = S_LOAD;
        k_d     = '0;
      end
      S_LOAD: begin
        k_d = k_q + ADDR_W'(1);
        if (last_beat) begin
          state_d = S_DRAIN;
          cnt_d   = '0;
        end
      end
      S_DRAIN: begin
        cnt_d = cnt_q + 8'd1;
        if (drain_end) begin
          state_d = S_WAIT;
          cnt_d   = '0;
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q + 8'd1;
        if (wait_end) begin
          state_d = S_CAPTURE;
          class_d = class_in;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state_q <= S_IDLE;
      k_q     <= '0;
      cnt_q   <= '0;
      class_q <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      cnt_q   <= cnt_d;
      class_q <= class_d;
    end
  assign rom_rd     = state_q == S_LOAD;
  assign rom_addr_a = rom_rd ? ADDR_W'({k_q, 1'b0}) : '0;
  assign rom_addr_b = rom_rd ? ADDR_W'({k_q, 1'b1}) : '0;
  // the final beat of an odd-sized load carries no odd word
  assign odd_valid  = rom_rd && !(last_beat && ODD);
  assign busy       = state_q != S_IDLE;
  assign done       = state_q == S_CAPTURE;
  assign class_out  = class_q;
  ann_strobe_delay #(.DEPTH(ROM_LATENCY), .WIDTH(ADDR_W + 2)) u_dly (
    .clk  (clk),
    .rst_n(reset),
    .din  ({rom_rd, odd_valid, rom_addr_a}),
    .dout ({buf_wr_a, buf_wr_b, buf_idx})
  );
endmodule
